// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - FSM state encoding (IDLE/REQ/WAIT_R/DONE)
//   - funct3 codes for loads and stores
//   - LSU_ERR_DATA: load result returned on a bus timeout
//   - lsu_misaligned(): access-size alignment check
package lsu_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] LSU_ERR_DATA = 32'hdeadbeaf;

    // funct3[1:0] carries the access size; 11 is treated as a word.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the LSU.
//   Store side: i_st_funct3/i_st_addr/i_st_wdata -> o_st_wstrb/o_st_wdata
//               (data replicated across lanes, strobes select the bytes).
//   Load side:  i_ld_funct3/i_ld_addr/i_ld_rdata -> o_ld_data
//               (byte/half selected by address, sign or zero extended).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_wstrb,
    output logic [31:0] o_st_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_wstrb = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (i_st_funct3[1:0])
            2'b00: begin
                o_st_wstrb = 4'b0001 << i_st_addr;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            2'b01: begin
                o_st_wstrb = 4'b0011 << i_st_addr;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = i_ld_rdata[{i_ld_addr, 3'b000} +: 8];
    assign w_half = i_ld_rdata[{i_ld_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_ld_data = {24'd0, w_byte};
            F3_LHU:  o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit between the core and a valid/ready
// data bus.
//   Core side: req_ren/req_wen/req_funct3/req_addr/req_wdata in;
//              stall, done, ld_data, misalign, err out.
//   Bus side:  bus_valid/bus_we/bus_addr/bus_wdata/bus_wstrb out, bus_ready in;
//              bus_rvalid/bus_rdata in.
//   Optional macro LSU_TIMEOUT_EN: abort an access after TIMEOUT cycles in
//   REQ/WAIT_R with err=1 and ld_data=LSU_ERR_DATA.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] ld_data,
    output logic              misalign,
    output logic              err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    logic [1:0]        r_state;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_misalign;
    logic [DATA_W-1:0] r_ld_data;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_bus_we;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [3:0]        r_bus_wstrb;

    logic              w_req;
    logic              w_mis;
    logic              w_tmo;
    logic [3:0]        w_st_wstrb;
    logic [DATA_W-1:0] w_st_wdata;
    logic [DATA_W-1:0] w_ld_ext;

    assign w_req = req_ren | req_wen;
    assign w_mis = lsu_misaligned(req_funct3, req_addr[1:0]);

    // Store lanes come from the live request (registered at accept);
    // load extension uses the latched funct3/offset.
    lsu_align u_align (
        .i_st_funct3 (req_funct3),
        .i_st_addr   (req_addr[1:0]),
        .i_st_wdata  (req_wdata),
        .o_st_wstrb  (w_st_wstrb),
        .o_st_wdata  (w_st_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_addr   (r_addr_lo),
        .i_ld_rdata  (bus_rdata),
        .o_ld_data   (w_ld_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_misalign  <= 1'b0;
            r_ld_data   <= '0;
            r_bus_addr  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_funct3    <= req_funct3;
                    r_addr_lo   <= req_addr[1:0];
                    r_misalign  <= w_mis;
                    r_ld_data   <= '0;
                    r_bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    r_bus_we    <= req_wen;
                    r_bus_wdata <= w_st_wdata;
                    r_bus_wstrb <= w_st_wstrb;
                    r_state     <= w_mis ? S_DONE : S_REQ;
                end
                S_REQ: begin
                    if (bus_ready) begin
                        r_state <= r_bus_we ? S_DONE : S_WAIT_R;
                    end else if (w_tmo) begin
                        r_ld_data <= LSU_ERR_DATA;
                        r_state   <= S_DONE;
                    end
                end
                S_WAIT_R: begin
                    if (bus_rvalid) begin
                        r_ld_data <= w_ld_ext;
                        r_state   <= S_DONE;
                    end else if (w_tmo) begin
                        r_ld_data <= LSU_ERR_DATA;
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;   // DONE: one commit cycle
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_err;

    // A handshake in the final cycle still wins over the abort.
    assign w_tmo = (r_tmo_cnt == TMO_LAST) &&
                   ((r_state == S_REQ    && !bus_ready) ||
                    (r_state == S_WAIT_R && !bus_rvalid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            // REQ is only entered from IDLE, so clearing in IDLE clears on entry.
            if (r_state == S_IDLE)
                r_tmo_cnt <= '0;
            else if (r_state == S_REQ || r_state == S_WAIT_R)
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            if (r_state == S_IDLE && w_req)
                r_err <= 1'b0;
            else if (w_tmo)
                r_err <= 1'b1;
        end
    end

    assign err = (r_state == S_DONE) && r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    assign stall     = (r_state == S_IDLE && w_req) || r_state == S_REQ || r_state == S_WAIT_R;
    assign done      = (r_state == S_DONE);
    assign misalign  = (r_state == S_DONE) && r_misalign;
    assign ld_data   = r_ld_data;
    assign bus_valid = (r_state == S_REQ);
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wstrb = r_bus_wstrb;

endmodule
